// File: rtl/word_combine.sv
// word_combine
//
// Packs sixteen discrete status/fault lines into one registered 16-bit word.
// Each line is passed through a two-flop synchronizer and a glitch filter.
// Lines selected in STICKY_MASK are then held high until cleared. The packed
// word is registered, and a one-cycle strobe marks every change of it.
//
// Parameters:
//   FILT_LEN     consecutive clk cycles a synchronized bit must disagree with
//                its accepted value before the new value is taken (1..255)
//   STICKY_MASK  bit i = 1 makes WordOut[i] hold high until cleared by clr
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous, active-high reset
//   bit0..bit15   asynchronous discrete inputs; bitN maps to WordOut[N]
//   clr           level-sampled clear for sticky bits
//   WordOut       packed, filtered, latched word
//   changed       one-cycle pulse on every update of WordOut
//   any           registered OR of WordOut, updated with WordOut

module word_combine #(
    parameter int          FILT_LEN    = 4,
    parameter logic [15:0] STICKY_MASK = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit0,
    input  logic        bit1,
    input  logic        bit2,
    input  logic        bit3,
    input  logic        bit4,
    input  logic        bit5,
    input  logic        bit6,
    input  logic        bit7,
    input  logic        bit8,
    input  logic        bit9,
    input  logic        bit10,
    input  logic        bit11,
    input  logic        bit12,
    input  logic        bit13,
    input  logic        bit14,
    input  logic        bit15,
    input  logic        clr,
    output logic [15:0] WordOut,
    output logic        changed,
    output logic        any
);

    // Counter only has to reach FILT_LEN-1, so this width can never wrap.
    localparam int              CW      = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(FILT_LEN - 1);

    logic [15:0]   raw_bits;
    logic [15:0]   s1;
    logic [15:0]   s2;
    logic [15:0]   filt;
    logic [CW-1:0] cnt [16];
    logic [15:0]   word_next;

    assign raw_bits = {bit15, bit14, bit13, bit12, bit11, bit10, bit9, bit8,
                       bit7,  bit6,  bit5,  bit4,  bit3,  bit2,  bit1, bit0};

    // Two-flop synchronizer for every input line.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw_bits;
            s2 <= s1;
        end
    end

    // Glitch filter: a bit must disagree with its accepted value for FILT_LEN
    // consecutive cycles before it is accepted; a single cycle of agreement
    // restarts the count, and reset throws away any partial count.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt <= '0;
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (s2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    filt[i] <= s2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Sticky bits keep their old 1 unless clr is high; the filtered value is
    // ORed in last so a live input always wins over a clear.
    always_comb begin
        word_next = filt | (WordOut & STICKY_MASK & {16{~clr}});
    end

    // Output register; changed and any are derived from the value being
    // loaded so they line up with WordOut on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            WordOut <= '0;
            changed <= 1'b0;
            any     <= 1'b0;
        end else begin
            WordOut <= word_next;
            changed <= (word_next != WordOut);
            any     <= |word_next;
        end
    end

endmodule

// File: tb/tb_word_combine.sv
// tb_word_combine
//
// Bench for word_combine. Three instances share one input stimulus:
//   A: FILT_LEN=4, STICKY_MASK=16'h8001
//   B: FILT_LEN=1, STICKY_MASK=16'h0000
//   C: FILT_LEN=8, STICKY_MASK=16'h0000
// Every cycle all three are compared with a behavioural model that accepts a
// new bit value once the last FILT_LEN synchronized samples all disagree with
// the accepted one. A table of hand-computed vectors and a few directed
// sequences pin down exact latencies for the corner cases.

module tb_word_combine;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [15:0] din;

    logic [15:0] wordA, wordB, wordC;
    logic        chgA, chgB, chgC;
    logic        anyA, anyB, anyC;

    int total;
    int bad;

    // Model state, one slot per instance.
    int          flen [3];
    logic [15:0] smask [3];
    logic [15:0] mS1 [3];
    logic [15:0] mS2 [3];
    logic [15:0] mFilt [3];
    logic [15:0] mWord [3];
    logic        mChg [3];
    logic        mAny [3];
    logic [15:0] mHist [3][16];
    int          mHistCnt [3];

    typedef struct {
        logic        rst;
        logic [15:0] bits;
        logic        clr;
        int          n;
        logic [15:0] expWord;
        logic        expChg;
        logic        expAny;
    } vec_t;

    vec_t vecs [27];

    word_combine #(.FILT_LEN(4), .STICKY_MASK(16'h8001)) dutA (
        .clk(clk), .rst(rst),
        .bit0(din[0]),   .bit1(din[1]),   .bit2(din[2]),   .bit3(din[3]),
        .bit4(din[4]),   .bit5(din[5]),   .bit6(din[6]),   .bit7(din[7]),
        .bit8(din[8]),   .bit9(din[9]),   .bit10(din[10]), .bit11(din[11]),
        .bit12(din[12]), .bit13(din[13]), .bit14(din[14]), .bit15(din[15]),
        .clr(clr), .WordOut(wordA), .changed(chgA), .any(anyA)
    );

    word_combine #(.FILT_LEN(1), .STICKY_MASK(16'h0000)) dutB (
        .clk(clk), .rst(rst),
        .bit0(din[0]),   .bit1(din[1]),   .bit2(din[2]),   .bit3(din[3]),
        .bit4(din[4]),   .bit5(din[5]),   .bit6(din[6]),   .bit7(din[7]),
        .bit8(din[8]),   .bit9(din[9]),   .bit10(din[10]), .bit11(din[11]),
        .bit12(din[12]), .bit13(din[13]), .bit14(din[14]), .bit15(din[15]),
        .clr(clr), .WordOut(wordB), .changed(chgB), .any(anyB)
    );

    word_combine #(.FILT_LEN(8), .STICKY_MASK(16'h0000)) dutC (
        .clk(clk), .rst(rst),
        .bit0(din[0]),   .bit1(din[1]),   .bit2(din[2]),   .bit3(din[3]),
        .bit4(din[4]),   .bit5(din[5]),   .bit6(din[6]),   .bit7(din[7]),
        .bit8(din[8]),   .bit9(din[9]),   .bit10(din[10]), .bit11(din[11]),
        .bit12(din[12]), .bit13(din[13]), .bit14(din[14]), .bit15(din[15]),
        .clr(clr), .WordOut(wordC), .changed(chgC), .any(anyC)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] dutWord(input int m);
        case (m)
            0:       return wordA;
            1:       return wordB;
            default: return wordC;
        endcase
    endfunction

    function automatic logic dutChg(input int m);
        case (m)
            0:       return chgA;
            1:       return chgB;
            default: return chgC;
        endcase
    endfunction

    function automatic logic dutAny(input int m);
        case (m)
            0:       return anyA;
            1:       return anyB;
            default: return anyC;
        endcase
    endfunction

    task automatic checkOutput(input string what, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", what, act, exp, $time);
        end
    endtask

    // Advance the model of instance m by one rising edge.
    task automatic modelEdge(input int m, input logic r, input logic [15:0] b, input logic c);
        logic [15:0] nextFilt;
        logic [15:0] nextWord;
        logic        allDiff;
        if (r) begin
            mS1[m]      = '0;
            mS2[m]      = '0;
            mFilt[m]    = '0;
            mWord[m]    = '0;
            mChg[m]     = 1'b0;
            mAny[m]     = 1'b0;
            mHistCnt[m] = 0;
            for (int k = 0; k < 16; k++) mHist[m][k] = '0;
        end else begin
            for (int k = 15; k > 0; k--) mHist[m][k] = mHist[m][k-1];
            mHist[m][0] = mS2[m];
            if (mHistCnt[m] < 16) mHistCnt[m]++;
            nextFilt = mFilt[m];
            for (int i = 0; i < 16; i++) begin
                if (mHistCnt[m] >= flen[m]) begin
                    allDiff = 1'b1;
                    for (int k = 0; k < flen[m]; k++) begin
                        if (mHist[m][k][i] == mFilt[m][i]) allDiff = 1'b0;
                    end
                    if (allDiff) nextFilt[i] = ~mFilt[m][i];
                end
            end
            nextWord = mFilt[m] | (mWord[m] & smask[m] & {16{~c}});
            mChg[m]  = (nextWord != mWord[m]);
            mAny[m]  = |nextWord;
            mWord[m] = nextWord;
            mFilt[m] = nextFilt;
            mS2[m]   = mS1[m];
            mS1[m]   = b;
        end
    endtask

    // Drive one cycle of inputs, step the models at the rising edge, and
    // compare all three instances against them on the falling edge.
    task automatic applyStimulus(input logic r, input logic [15:0] b, input logic c);
        rst = r;
        din = b;
        clr = c;
        @(posedge clk);
        for (int m = 0; m < 3; m++) modelEdge(m, r, b, c);
        @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            checkOutput($sformatf("model%0d word", m), dutWord(m), mWord[m]);
            checkOutput($sformatf("model%0d changed", m), {15'b0, dutChg(m)}, {15'b0, mChg[m]});
            checkOutput($sformatf("model%0d any", m), {15'b0, dutAny(m)}, {15'b0, mAny[m]});
        end
    endtask

    initial begin
        logic [15:0] cur;
        int          holdLeft;
        logic        drv [32];
        logic        expBit;
        logic        prevBit;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clr   = 1'b0;
        din   = '0;
        flen  = '{4, 1, 8};
        smask = '{16'h8001, 16'h0000, 16'h0000};

        // Vectors for instance A: {rst, bits, clr, cycles, word, changed, any}.
        vecs[0]  = '{1'b1, 16'hFFFF, 1'b0, 5, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 16'hFFFF, 1'b0, 6, 16'h0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 16'hFFFF, 1'b0, 1, 16'hFFFF, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 16'hFFFF, 1'b0, 1, 16'hFFFF, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 16'h0000, 1'b1, 6, 16'hFFFF, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1, 16'h0000, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 16'h0000, 1'b0, 3, 16'h0000, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 16'h0008, 1'b0, 3, 16'h0000, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, 8, 16'h0000, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 16'h0008, 1'b0, 4, 16'h0000, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 2, 16'h0000, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 1, 16'h0008, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 3, 16'h0008, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 16'h0000, 1'b0, 1, 16'h0000, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 16'h0000, 1'b0, 2, 16'h0000, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 16'h8002, 1'b0, 6, 16'h0000, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 16'h8002, 1'b0, 1, 16'h8002, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 16'h8002, 1'b0, 3, 16'h8002, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 16'h0000, 1'b0, 6, 16'h8002, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 16'h0000, 1'b0, 1, 16'h8000, 1'b1, 1'b1};
        vecs[20] = '{1'b0, 16'h0000, 1'b0, 2, 16'h8000, 1'b0, 1'b1};
        vecs[21] = '{1'b0, 16'h0000, 1'b1, 1, 16'h0000, 1'b1, 1'b0};
        vecs[22] = '{1'b0, 16'h0000, 1'b0, 2, 16'h0000, 1'b0, 1'b0};
        vecs[23] = '{1'b0, 16'h0001, 1'b0, 6, 16'h0000, 1'b0, 1'b0};
        vecs[24] = '{1'b0, 16'h0001, 1'b0, 1, 16'h0001, 1'b1, 1'b1};
        vecs[25] = '{1'b0, 16'h0001, 1'b1, 3, 16'h0001, 1'b0, 1'b1};
        vecs[26] = '{1'b0, 16'h0001, 1'b0, 2, 16'h0001, 1'b0, 1'b1};

        $display("[TB] table vectors on instance A");
        for (int v = 0; v < 27; v++) begin
            for (int j = 0; j < vecs[v].n; j++) begin
                applyStimulus(vecs[v].rst, vecs[v].bits, vecs[v].clr);
                checkOutput($sformatf("vec%0d.%0d word", v, j), wordA, vecs[v].expWord);
                checkOutput($sformatf("vec%0d.%0d changed", v, j), {15'b0, chgA}, {15'b0, vecs[v].expChg});
                checkOutput($sformatf("vec%0d.%0d any", v, j), {15'b0, anyA}, {15'b0, vecs[v].expAny});
            end
        end

        // FILT_LEN=1: bit0 toggles every two cycles and should reappear on
        // WordOut[0] three edges after the edge that captured it.
        $display("[TB] minimum filter toggle on instance B");
        applyStimulus(1'b1, 16'h0000, 1'b0);
        applyStimulus(1'b1, 16'h0000, 1'b0);
        for (int j = 0; j < 12; j++) applyStimulus(1'b0, 16'h0000, 1'b0);
        for (int k = 0; k < 32; k++) drv[k] = ((k / 2) % 2) == 1;
        for (int k = 0; k < 32; k++) begin
            applyStimulus(1'b0, {15'b0, drv[k]}, 1'b0);
            expBit  = (k >= 3) ? drv[k-3] : 1'b0;
            prevBit = (k >= 4) ? drv[k-4] : 1'b0;
            checkOutput($sformatf("toggle%0d word", k), wordB, {15'b0, expBit});
            checkOutput($sformatf("toggle%0d changed", k), {15'b0, chgB}, {15'b0, expBit != prevBit});
        end

        // FILT_LEN=8: reset lands partway through a count; the full latency
        // must be paid again after release.
        $display("[TB] reset mid-filter on instance C");
        applyStimulus(1'b1, 16'h0000, 1'b0);
        for (int j = 0; j < 12; j++) applyStimulus(1'b0, 16'h0000, 1'b0);
        for (int j = 0; j < 6; j++) applyStimulus(1'b0, 16'h0080, 1'b0);
        applyStimulus(1'b1, 16'h0080, 1'b0);
        checkOutput("midreset word", wordC, 16'h0000);
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1'b0, 16'h0080, 1'b0);
            checkOutput($sformatf("midreset edge%0d word", k), wordC,
                        (k >= 11) ? 16'h0080 : 16'h0000);
            checkOutput($sformatf("midreset edge%0d changed", k), {15'b0, chgC},
                        {15'b0, k == 11});
        end

        // Random runs of held patterns, with occasional clears and resets.
        $display("[TB] random stimulus against model");
        cur      = '0;
        holdLeft = 0;
        for (int n = 0; n < 600; n++) begin
            if (holdLeft == 0) begin
                cur      = cur ^ (16'($urandom) & 16'($urandom));
                holdLeft = $urandom_range(1, 12);
            end
            holdLeft--;
            applyStimulus($urandom_range(0, 99) == 0, cur, $urandom_range(0, 7) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
